// File: rtl/memwb_pkg.sv
// Shared types and constants for the memory/writeback stage.
package memwb_pkg;

    typedef enum logic [1:0] {
        MW_IDLE,
        MW_REQ,
        MW_DONE
    } memwb_state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // True when the low address bits place a word access off a word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// M->W pipeline register with synchronous reset and a bubble input.
// A bubble clears the write-enabling controls and holds the data fields,
// so ResultW and WriteAddrW keep their previous values during stalls.
module memwb_reg #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble,
    input  logic              pcsrc_m,
    input  logic              regwrite_m,
    input  logic              memtoreg_m,
    input  logic [AWIDTH-1:0] writeaddr_m,
    input  logic [DWIDTH-1:0] aluresult_m,
    input  logic [DWIDTH-1:0] loaddata_m,
    output logic              pcsrc_w,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic [AWIDTH-1:0] writeaddr_w,
    output logic [DWIDTH-1:0] aluresult_w,
    output logic [DWIDTH-1:0] loaddata_w
);

    // Capture the M-stage instruction, or insert a bubble while stalled/discarded.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            pcsrc_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            memtoreg_w  <= 1'b0;
            writeaddr_w <= '0;
            aluresult_w <= '0;
            loaddata_w  <= '0;
        end else if (bubble) begin
            pcsrc_w    <= 1'b0;
            regwrite_w <= 1'b0;
        end else begin
            pcsrc_w     <= pcsrc_m;
            regwrite_w  <= regwrite_m;
            memtoreg_w  <= memtoreg_m;
            writeaddr_w <= writeaddr_m;
            aluresult_w <= aluresult_m;
            loaddata_w  <= loaddata_m;
        end
    end

endmodule

// File: rtl/memwb.sv
// Memory/writeback stage: word loads/stores over a req/ack port, stalling
// the pipeline while an access is outstanding, then registering into W.
module memwb
    import memwb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [DWIDTH-1:0] ALUResultM,
    input  logic [DWIDTH-1:0] WriteDataM,
    input  logic [3:0]        WriteAddrM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              MemStall,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic [3:0]        WriteAddrW,
    output logic [DWIDTH-1:0] ResultW,
    output logic              AlignFault
);

    memwb_state_t      state_q;
    memwb_state_t      state_d;
    logic              mem_op;
    logic              misaligned;
    logic              start_access;
    logic              bubble;
    logic [DWIDTH-1:0] load_data_q;
    logic              memtoreg_w;
    logic [DWIDTH-1:0] aluresult_w;
    logic [DWIDTH-1:0] loaddata_w;

    assign mem_op     = MemtoRegM | MemWriteM;
    assign misaligned = mem_op && is_misaligned(ALUResultM[1:0]);

    // A misaligned op is dropped in IDLE without stalling; W still sees a bubble.
    assign bubble = MemStall | ((state_q == MW_IDLE) && misaligned);

    // Next-state and stall decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        MemStall     = 1'b0;
        start_access = 1'b0;
        case (state_q)
            MW_IDLE: begin
                if (mem_op && !misaligned) begin
                    state_d      = MW_REQ;
                    MemStall     = 1'b1;
                    start_access = 1'b1;
                end
            end
            MW_REQ: begin
                MemStall = 1'b1;
                if (dmem_ack) begin
                    state_d = MW_DONE;
                end
            end
            MW_DONE: begin
                state_d = MW_IDLE;
            end
            default: begin
                state_d = MW_IDLE;
            end
        endcase
    end

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered memory port; address/data/we latched once on entry to REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            dmem_req <= (state_d == MW_REQ);
            if (start_access) begin
                dmem_we    <= MemWriteM;
                dmem_addr  <= ALUResultM;
                dmem_wdata <= WriteDataM;
            end
        end
    end

    // Load data captured on ack; acks outside REQ are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_data_q <= '0;
        end else if ((state_q == MW_REQ) && dmem_ack) begin
            load_data_q <= dmem_rdata;
        end
    end

    // One-cycle fault pulse after a misaligned op leaves M.
    always_ff @(posedge clk) begin
        if (reset) begin
            AlignFault <= 1'b0;
        end else begin
            AlignFault <= (state_q == MW_IDLE) && misaligned;
        end
    end

    memwb_reg #(
        .DWIDTH (DWIDTH),
        .AWIDTH (4)
    ) u_memwb_reg (
        .clk         (clk),
        .reset       (reset),
        .bubble      (bubble),
        .pcsrc_m     (PCSrcM),
        .regwrite_m  (RegWriteM),
        .memtoreg_m  (MemtoRegM),
        .writeaddr_m (WriteAddrM),
        .aluresult_m (ALUResultM),
        .loaddata_m  (load_data_q),
        .pcsrc_w     (PCSrcW),
        .regwrite_w  (RegWriteW),
        .memtoreg_w  (memtoreg_w),
        .writeaddr_w (WriteAddrW),
        .aluresult_w (aluresult_w),
        .loaddata_w  (loaddata_w)
    );

    assign ResultW = memtoreg_w ? loaddata_w : aluresult_w;

endmodule

// File: tb/tb_memwb.sv
// Directed self-checking bench for the memory/writeback stage.
module tb_memwb;

    logic        clk;
    logic        reset;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [3:0]  WriteAddrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        MemStall;
    logic        PCSrcW, RegWriteW;
    logic [3:0]  WriteAddrW;
    logic [31:0] ResultW;
    logic        AlignFault;

    int n_checks = 0;
    int n_fail   = 0;

    memwb #(.DWIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcM     (PCSrcM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .WriteAddrM (WriteAddrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .MemStall   (MemStall),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .WriteAddrW (WriteAddrW),
        .ResultW    (ResultW),
        .AlignFault (AlignFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic pcsrc, input logic regwrite, input logic memtoreg,
                          input logic memwrite, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic [3:0] waddr);
        PCSrcM     = pcsrc;
        RegWriteM  = regwrite;
        MemtoRegM  = memtoreg;
        MemWriteM  = memwrite;
        ALUResultM = alu;
        WriteDataM = wdata;
        WriteAddrM = waddr;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        tick();
        tick();
        #1;
        // Reset state
        check("rst_req",    dmem_req,   0);
        check("rst_we",     dmem_we,    0);
        check("rst_addr",   dmem_addr,  0);
        check("rst_wdata",  dmem_wdata, 0);
        check("rst_stall",  MemStall,   0);
        check("rst_pcsrc",  PCSrcW,     0);
        check("rst_regw",   RegWriteW,  0);
        check("rst_waddr",  WriteAddrW, 0);
        check("rst_result", ResultW,    0);
        check("rst_fault",  AlignFault, 0);
        tick();
        reset = 1'b0;

        // ADD: one cycle M->W
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'd3);
        #1 check("add_stall", MemStall, 0);
        tick();
        nop();
        check("add_regw",   RegWriteW,  1);
        check("add_waddr",  WriteAddrW, 3);
        check("add_result", ResultW,    32'h0000_1234);
        check("add_pcsrc",  PCSrcW,     0);

        // Branch: PCSrc passes through
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'd15);
        tick();
        nop();
        check("br_pcsrc", PCSrcW, 1);
        check("br_regw",  RegWriteW, 0);

        // ADD again to establish known held W values
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'd3);
        tick();

        // LDR 0x100, ack in second REQ cycle
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'd5);
        #1;
        check("ldr_idle_stall", MemStall, 1);
        check("ldr_idle_req",   dmem_req, 0);
        tick();
        check("ldr_req1_req",   dmem_req,   1);
        check("ldr_req1_addr",  dmem_addr,  32'h0000_0100);
        check("ldr_req1_we",    dmem_we,    0);
        check("ldr_req1_stall", MemStall,   1);
        check("ldr_req1_regw",  RegWriteW,  0);
        check("ldr_req1_waddr", WriteAddrW, 3);
        check("ldr_req1_res",   ResultW,    32'h0000_1234);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ldr_req2_req",   dmem_req,  1);
        check("ldr_req2_addr",  dmem_addr, 32'h0000_0100);
        check("ldr_req2_stall", MemStall,  1);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        check("ldr_done_req",   dmem_req,  0);
        check("ldr_done_stall", MemStall,  0);
        check("ldr_done_regw",  RegWriteW, 0);
        tick();
        nop();
        check("ldr_w_result", ResultW,    32'hDEAD_BEEF);
        check("ldr_w_regw",   RegWriteW,  1);
        check("ldr_w_waddr",  WriteAddrW, 5);

        // STR 0x200, same-cycle ack
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'd7);
        #1 check("str_idle_stall", MemStall, 1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        #1;
        check("str_req_req",   dmem_req,   1);
        check("str_req_we",    dmem_we,    1);
        check("str_req_wdata", dmem_wdata, 32'hCAFE_F00D);
        check("str_req_addr",  dmem_addr,  32'h0000_0200);
        check("str_req_stall", MemStall,   1);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        check("str_done_req",   dmem_req, 0);
        check("str_done_stall", MemStall, 0);
        tick();
        nop();
        check("str_w_regw",   RegWriteW,  0);
        check("str_w_waddr",  WriteAddrW, 7);
        check("str_w_result", ResultW,    32'h0000_0200);

        // Misaligned LDR 0x102
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 4'd9);
        #1;
        check("mis_stall", MemStall,   0);
        check("mis_fault0", AlignFault, 0);
        tick();
        nop();
        check("mis_fault1", AlignFault, 1);
        check("mis_req",    dmem_req,   0);
        check("mis_regw",   RegWriteW,  0);
        check("mis_waddr",  WriteAddrW, 7);
        tick();
        check("mis_fault2", AlignFault, 0);
        check("mis_req2",   dmem_req,   0);

        // Reset asserted mid-REQ, late ack afterwards
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'd4);
        tick();
        check("rreq_req", dmem_req, 1);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        #1;
        check("rreq_req_after", dmem_req,   0);
        check("rreq_stall",     MemStall,   0);
        check("rreq_regw",      RegWriteW,  0);
        check("rreq_waddr",     WriteAddrW, 0);
        check("rreq_result",    ResultW,    0);
        check("rreq_pcsrc",     PCSrcW,     0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        check("rreq_late_req",   dmem_req,  0);
        check("rreq_late_stall", MemStall,  0);
        check("rreq_late_res",   ResultW,   0);

        // Back-to-back LDR, LDR
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'd1);
        #1 check("b2b_a_idle_req", dmem_req, 0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1;
        check("b2b_a_req",  dmem_req,  1);
        check("b2b_a_addr", dmem_addr, 32'h0000_0400);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1 check("b2b_a_done_req", dmem_req, 0);
        tick();
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'd2);
        #1;
        check("b2b_a_result",   ResultW,    32'h1111_2222);
        check("b2b_a_waddr",    WriteAddrW, 1);
        check("b2b_a_regw",     RegWriteW,  1);
        check("b2b_b_idle_req", dmem_req,   0);
        check("b2b_b_stall",    MemStall,   1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h3333_4444;
        #1;
        check("b2b_b_req",  dmem_req,  1);
        check("b2b_b_addr", dmem_addr, 32'h0000_0404);
        check("b2b_b_regw", RegWriteW, 0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1 check("b2b_b_done_req", dmem_req, 0);
        tick();
        nop();
        check("b2b_b_result", ResultW,    32'h3333_4444);
        check("b2b_b_waddr",  WriteAddrW, 2);
        check("b2b_b_regw",   RegWriteW,  1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memwb.md
# memwb

Memory/writeback stage of the pipelined ARM core. Consumes the M-stage control and data produced by `Exec`. Performs word loads and stores over a req/ack data-memory port, holding the pipeline with `MemStall` while an access is outstanding. Registers the result into the W stage and supplies `ResultW` for register-file write and operand forwarding.

## Interface
Parameters:
- `DWIDTH`, 32, data/address width; fixed word access, byte address.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `PCSrcM, RegWriteM, MemtoRegM, MemWriteM`  in  1 each  M-stage controls from `Exec`.
- `ALUResultM`  in  32  ALU result; memory address for loads/stores.
- `WriteDataM`  in  32  store data.
- `WriteAddrM`  in  4  destination register.
- `dmem_req`  out  1  access request, registered.
- `dmem_we`  out  1  1 = store, registered.
- `dmem_addr`  out  32  word-aligned address, registered.
- `dmem_wdata`  out  32  store data, registered.
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid same cycle.
- `dmem_rdata`  in  32  load data.
- `MemStall`  out  1  combinational; upstream holds all M inputs stable while high.
- `PCSrcW, RegWriteW`  out  1 each  W-stage controls.
- `WriteAddrW`  out  4  W-stage destination.
- `ResultW`  out  32  `MemtoRegW ? load data : ALU result`.
- `AlignFault`  out  1  one-cycle pulse: misaligned load/store discarded.

## Operation
- Memory op = `MemtoRegM | MemWriteM`. Misaligned = memory op with `ALUResultM[1:0] != 0`.
- FSM states:
  - IDLE: `dmem_req=0`.
    - Aligned memory op present: latch addr/wdata/we, go to REQ. `MemStall=1` this cycle.
    - Otherwise: `MemStall=0`; M captured into W at the edge.
  - REQ: `dmem_req=1`, `MemStall=1`.
    - On `dmem_ack`: latch `dmem_rdata` into the load-data register and go to DONE.
    - Otherwise stay in REQ. No timeout.
  - DONE: `dmem_req=0`, `MemStall=0`. W captures the instruction, using the load-data register when `MemtoRegM`. Go to IDLE.
- While `MemStall=1`, W receives a bubble: `RegWriteW=0`, `PCSrcW=0`. `ResultW` and `WriteAddrW` are don't-care but hold their previous values.
- Misaligned op: no memory request, `MemStall=0`. W receives a bubble. `AlignFault` is high in the cycle after the op leaves M.
- Stores complete on ack; `dmem_rdata` is ignored. `RegWriteW` follows `RegWriteM` (normally 0).
- `dmem_ack` is ignored in IDLE and DONE.
- A second memory op arriving directly after DONE starts a fresh IDLE→REQ sequence. No back-to-back overlap.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, load-data register = 0; `PCSrcW`, `RegWriteW`, `WriteAddrW`, `ResultW`, `AlignFault` = 0.
- Non-memory op: 1 cycle M→W.
- Memory op: minimum 3 cycles in M (IDLE, REQ with same-cycle ack, DONE). Each extra wait cycle in REQ adds 1.
- `dmem_addr`, `dmem_wdata` and `dmem_we` stay constant for the whole REQ state.
- Reset asserted in REQ: `dmem_req=0` from the next cycle. The abandoned access's late ack is ignored in IDLE.
- Reset has priority over every transition.

## Structure
- Shared package `memwb_pkg`:
  - `typedef enum logic [1:0] {MW_IDLE, MW_REQ, MW_DONE} memwb_state_t`.
  - Constant `WORD_ALIGN_MASK = 2'b11`.
- One sub-module `memwb_reg`: the M→W pipeline register with a synchronous bubble input and reset, holding PCSrc, RegWrite, MemtoReg, WriteAddr, ALUResult and load data.
- FSM, address/data latches and the result mux live in `memwb`.

## Test plan
- ADD result 0x0000_1234, `RegWriteM=1`, `WriteAddrM=3`, `MemStall=0` → next cycle `RegWriteW=1`, `WriteAddrW=3`, `ResultW=0x1234`.
- LDR addr 0x100, ack 2 cycles after req, `rdata=0xDEADBEEF` → `MemStall` high 3 cycles. `dmem_addr=0x100` is stable throughout. Then `ResultW=0xDEADBEEF`, `RegWriteW=1`, with W bubbles during the stall.
- STR addr 0x200, data 0xCAFEF00D, same-cycle ack → `dmem_we=1`, `dmem_wdata=0xCAFEF00D` for 1 REQ cycle. Total 3 cycles in M; `RegWriteW=0`.
- LDR addr 0x102 → no `dmem_req`, `MemStall=0`, `AlignFault` high 1 cycle, `RegWriteW=0`.
- Reset asserted mid-REQ, ack arrives 1 cycle later → `dmem_req=0` after the reset edge. State stays IDLE; all W outputs are 0.
- Back-to-back LDR, LDR → two separate IDLE-REQ-DONE sequences, correct `ResultW` for each, with no shared request cycle.
